// File: rtl/ones_pattern_gen_pkg.sv
// ones_pattern_gen_pkg: shared defaults and state encoding for the ones pattern generator
//   DEF_N_BITS : default output vector width
//   DEF_CNT_W  : default count width, $clog2(DEF_N_BITS+1)
//   state_t    : FSM encoding; 2'd3 is illegal and recovers to ST_IDLE
package ones_pattern_gen_pkg;

    localparam int DEF_N_BITS = 127;
    localparam int DEF_CNT_W  = $clog2(DEF_N_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ones_tally.sv
// ones_tally: counts the ones inserted into a pattern and flags a mismatch against the request
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the tally (pattern accepted)
//   inc        : a one is being inserted this edge
//   chk        : last shift edge; compare the final tally against exp
//   exp        : latched requested count
//   chk_err    : sticky mismatch flag, cleared only by reset
module ones_tally #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             chk,
    input  logic [CNT_W-1:0] exp,
    output logic             chk_err
);

    logic [CNT_W-1:0] tally;
    logic [CNT_W-1:0] tally_nxt;

    // The final insertion happens on the same edge that enters DONE, so compare the updated value.
    always_comb tally_nxt = tally + CNT_W'(inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tally   <= '0;
            chk_err <= 1'b0;
        end else begin
            tally <= clr ? '0 : tally_nxt;
            if (chk && tally_nxt != exp) chk_err <= 1'b1;
        end
    end

endmodule

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: builds an N_BITS vector with the requested number of ones packed in the LSBs, one bit per clock
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : in_count valid
//   in_count   : requested number of ones (clamped to N_BITS)
//   in_ready   : idle and accepting
//   out_valid  : out_vector complete and stable
//   out_ready  : consumer takes out_vector
//   out_vector : generated pattern
//   chk_err    : sticky self-check error; only live with ONES_PATTERN_GEN_SELFCHECK_EN defined, else 0
module ones_pattern_gen
    import ones_pattern_gen_pkg::*;
#(
    parameter int N_BITS = DEF_N_BITS,
    parameter int CNT_W  = $clog2(N_BITS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CNT_W-1:0]  in_count,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] out_vector,
    output logic              chk_err
);

    state_t           state;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_sat;
    logic             accept;
    logic             last;
    logic             ins;

    always_comb begin
        cnt_sat = (in_count > CNT_W'(N_BITS)) ? CNT_W'(N_BITS) : in_count;
        accept  = (state == ST_IDLE) && in_valid && in_ready;
        last    = (state == ST_SHIFT) && (idx == CNT_W'(N_BITS - 1));
        ins     = idx < cnt_q;
    end

    // Each shift inserts at the MSB; after N_BITS shifts bit idx=0 lands in the LSB,
    // so the ones end up thermometer-packed low and the old content is fully flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            out_vector <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            idx        <= '0;
            cnt_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt_q    <= cnt_sat;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    out_vector <= {ins, out_vector[N_BITS-1:1]};
                    idx        <= idx + 1'b1;
                    if (last) begin
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ONES_PATTERN_GEN_SELFCHECK_EN
    ones_tally #(.CNT_W(CNT_W)) u_tally (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .inc     ((state == ST_SHIFT) && ins),
        .chk     (last),
        .exp     (cnt_q),
        .chk_err (chk_err)
    );
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb_ones_pattern_gen: directed self-checking bench for ones_pattern_gen
module tb_ones_pattern_gen;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [6:0]   in_count = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [126:0] out_vector;
    logic         chk_err;

    int checks = 0;
    int errors = 0;

    ones_pattern_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_count   (in_count),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vector (out_vector),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [126:0] got, input logic [126:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [126:0] thermo(input int c);
        logic [126:0] v = '0;
        for (int i = 0; i < c && i < 127; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int lat = 0;
        while (!out_valid && lat < 300) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, 127'(lat), 127'd127);
    endtask

    task automatic run(input logic [6:0] c, input logic [126:0] exp, input string tag);
        int w = 0;
        while (!in_ready && w < 300) begin
            step();
            w++;
        end
        chk({tag, " ready"}, 127'(in_ready), 127'd1);
        in_valid = 1'b1;
        in_count = c;
        step();
        in_valid = 1'b0;
        wait_done(tag);
        chk({tag, " vector"}, out_vector, exp);
        chk({tag, " chk_err"}, 127'(chk_err), 127'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " valid drop"}, 127'(out_valid), 127'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #5;
        chk("rst out_vector", out_vector, '0);
        chk("rst out_valid", 127'(out_valid), 127'd0);
        chk("rst in_ready", 127'(in_ready), 127'd1);
        chk("rst chk_err", 127'(chk_err), 127'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run(7'd0, '0, "count0");
        run(7'd127, {127{1'b1}}, "count127");
        run(7'd5, 127'h1F, "count5");

        // back-pressure plus a competing request held through SHIFT and DONE
        in_valid = 1'b1;
        in_count = 7'd5;
        step();
        in_count = 7'd9;
        wait_done("bp");
        chk("bp vector", out_vector, 127'h1F);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp hold valid", 127'(out_valid), 127'd1);
            chk("bp hold vector", out_vector, 127'h1F);
            chk("bp hold in_ready", 127'(in_ready), 127'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp valid drop", 127'(out_valid), 127'd0);
        chk("bp idle vector", out_vector, 127'h1F);
        chk("bp idle ready", 127'(in_ready), 127'd1);

        // reset mid-SHIFT
        in_valid = 1'b1;
        in_count = 7'd100;
        step();
        in_valid = 1'b0;
        repeat (60) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_vector", out_vector, '0);
        chk("midrst in_ready", 127'(in_ready), 127'd1);
        chk("midrst out_valid", 127'(out_valid), 127'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run(7'd3, 127'h7, "after rst count3");

        for (int c = 0; c <= 127; c++) begin
            run(7'(c), thermo(c), "sweep");
            chk("sweep popcount", 127'($countones(out_vector)), 127'(c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
